enable_sequencer: RTL and testbench

Timebase controller for the enable generation datapath. It owns the period counter, sequences start/stop/single-shot operation through a small FSM, and drives N independent enable channels from double-buffered period and threshold registers. All configuration changes take effect only on period boundaries. Sits between the control-register bus and the modulators and ADC triggers that consume the enables.

---
 rtl/enable_sequencer_pkg.sv | 14 +
 rtl/enable_channel.sv | 72 +++++++
 rtl/enable_sequencer.sv | 135 +++++++++++++
 tb/tb_enable_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/enable_sequencer_pkg.sv
// Shared types and constants for the enable sequencer: FSM states and
// configuration address map.
package enable_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam logic [3:0] CFG_ADDR_PERIOD  = 4'd0;
  localparam logic [3:0] CFG_ADDR_CH_BASE = 4'd1;

endpackage

// File: rtl/enable_channel.sv
// One enable channel: double-buffered threshold plus registered compare output.
// Build option ENABLE_SEQUENCER_CLOCK_MODE_EN turns the pulse into a clock-like waveform.
module enable_channel
  import enable_sequencer_pkg::*;
#(
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     shadow_load_i,
  input  logic                     write_i,
  input  logic                     eval_i,
  input  logic [COUNTER_WIDTH-1:0] data_i,
  input  logic [COUNTER_WIDTH-1:0] count_i,
  input  logic [COUNTER_WIDTH-1:0] period_i,
  output logic                     enable_o
);

  localparam logic [COUNTER_WIDTH-1:0] ONE = COUNTER_WIDTH'(1);

  logic [COUNTER_WIDTH-1:0] thr_active_q;
  logic [COUNTER_WIDTH-1:0] thr_shadow_q;
  logic [COUNTER_WIDTH-1:0] thr_m1;
  logic                     thr_nonzero;
  logic                     set_hit;
  logic                     enable_q;
  logic                     enable_d;

  // thr-1 is only meaningful when thr != 0; guard every use with thr_nonzero.
  assign thr_nonzero = (thr_shadow_q != '0);
  assign thr_m1      = thr_shadow_q - ONE;
  assign set_hit     = thr_nonzero && (thr_shadow_q < period_i) && (count_i == thr_m1);

`ifdef ENABLE_SEQUENCER_CLOCK_MODE_EN
  logic clr_hit;
  assign clr_hit = thr_nonzero && (count_i == (thr_m1 >> 1));

  always_comb begin
    enable_d = enable_q;
    if (!eval_i || !thr_nonzero) begin
      enable_d = 1'b0;
    end else if (set_hit) begin
      enable_d = 1'b1;
    end else if (clr_hit) begin
      enable_d = 1'b0;
    end
  end
`else
  always_comb begin
    enable_d = eval_i && set_hit;
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      thr_active_q <= '0;
      thr_shadow_q <= '0;
      enable_q     <= 1'b0;
    end else begin
      if (write_i) begin
        thr_active_q <= data_i;
      end
      if (shadow_load_i) begin
        thr_shadow_q <= thr_active_q;
      end
      enable_q <= enable_d;
    end
  end

  assign enable_o = enable_q;

endmodule

// File: rtl/enable_sequencer.sv
// Timebase controller: period counter, start/stop/single-shot FSM and N enable channels.
// Build option ENABLE_SEQUENCER_CLOCK_MODE_EN selects clock-like channel outputs.
module enable_sequencer
  import enable_sequencer_pkg::*;
#(
  parameter int COUNTER_WIDTH = 32,
  parameter int N_CHANNELS    = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     run,
  input  logic                     single_shot,
  input  logic                     cfg_write,
  input  logic [3:0]               cfg_address,
  input  logic [COUNTER_WIDTH-1:0] cfg_data,
  output logic [COUNTER_WIDTH-1:0] count,
  output logic [N_CHANNELS-1:0]    enable_out,
  output logic                     period_done,
  output logic                     busy,
  output logic                     config_error
);

  localparam logic [COUNTER_WIDTH-1:0] ONE = COUNTER_WIDTH'(1);
  localparam logic [COUNTER_WIDTH-1:0] TWO = COUNTER_WIDTH'(2);

  state_e                   state_q, state_d;
  logic                     continuous_q, continuous_d;
  logic [COUNTER_WIDTH-1:0] count_q, count_d;
  logic [COUNTER_WIDTH-1:0] period_active_q;
  logic [COUNTER_WIDTH-1:0] period_shadow_q;
  logic                     period_done_q, period_done_d;
  logic                     config_error_q, config_error_d;
  logic                     shadow_load;
  logic                     last_count;
  logic                     eval;

  // A period reprogrammed below 2 mid-run degrades to wrapping every cycle.
  assign last_count = (period_shadow_q < TWO) || (count_q == period_shadow_q - ONE);

  always_comb begin
    state_d        = state_q;
    continuous_d   = continuous_q;
    count_d        = count_q;
    period_done_d  = 1'b0;
    config_error_d = 1'b0;
    shadow_load    = 1'b0;
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (run || single_shot) begin
          state_d      = ARM;
          continuous_d = run;
        end
      end
      ARM: begin
        shadow_load = 1'b1;
        count_d     = '0;
        if (period_active_q < TWO) begin
          config_error_d = 1'b1;
          state_d        = IDLE;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_count) begin
          count_d       = '0;
          shadow_load   = 1'b1;
          period_done_d = 1'b1;
          if (!continuous_q || !run) begin
            state_d = IDLE;
          end
        end else begin
          count_d = count_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q         <= IDLE;
      continuous_q    <= 1'b0;
      count_q         <= '0;
      period_active_q <= '0;
      period_shadow_q <= '0;
      period_done_q   <= 1'b0;
      config_error_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      continuous_q   <= continuous_d;
      count_q        <= count_d;
      period_done_q  <= period_done_d;
      config_error_q <= config_error_d;
      if (cfg_write && (cfg_address == CFG_ADDR_PERIOD)) begin
        period_active_q <= cfg_data;
      end
      if (shadow_load) begin
        period_shadow_q <= period_active_q;
      end
    end
  end

  // Channels only compare while the FSM stays in RUN, so IDLE and ARM hold them low.
  assign eval = (state_q == RUN) && (state_d == RUN);

  genvar gi;
  generate
    for (gi = 0; gi < N_CHANNELS; gi++) begin : g_channel
      enable_channel #(
        .COUNTER_WIDTH(COUNTER_WIDTH)
      ) u_channel (
        .clock        (clock),
        .reset        (reset),
        .shadow_load_i(shadow_load),
        .write_i      (cfg_write && (cfg_address == CFG_ADDR_CH_BASE + 4'(gi))),
        .eval_i       (eval),
        .data_i       (cfg_data),
        .count_i      (count_q),
        .period_i     (period_shadow_q),
        .enable_o     (enable_out[gi])
      );
    end
  endgenerate

  assign count        = count_q;
  assign period_done  = period_done_q;
  assign busy         = (state_q != IDLE);
  assign config_error = config_error_q;

endmodule

// File: tb/tb_enable_sequencer.sv
// Directed self-checking bench for enable_sequencer; outputs sampled on the falling edge.
// Define ENABLE_SEQUENCER_CLOCK_MODE_EN to check the clock-like channel waveform.
module tb_enable_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic        single_shot;
  logic        cfg_write;
  logic [3:0]  cfg_address;
  logic [31:0] cfg_data;
  logic [31:0] count;
  logic [3:0]  enable_out;
  logic        period_done;
  logic        busy;
  logic        config_error;

  int n_checks = 0;
  int n_fail   = 0;

  enable_sequencer #(.COUNTER_WIDTH(32), .N_CHANNELS(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
    .single_shot (single_shot),
    .cfg_write   (cfg_write),
    .cfg_address (cfg_address),
    .cfg_data    (cfg_data),
    .count       (count),
    .enable_out  (enable_out),
    .period_done (period_done),
    .busy        (busy),
    .config_error(config_error)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic cfg_wr(input logic [3:0] addr, input logic [31:0] data);
    cfg_write   = 1'b1;
    cfg_address = addr;
    cfg_data    = data;
    tick();
    cfg_write   = 1'b0;
    $display("cfg write addr=%0d data=%0d", addr, data);
  endtask

  initial begin
    int busy_cycles;
    int cnt;
    logic [3:0] exp_en;
    bit waited;

    reset = 1'b0; run = 1'b0; single_shot = 1'b0;
    cfg_write = 1'b0; cfg_address = '0; cfg_data = '0;
    tick(); tick();
    reset = 1'b1;
    check("rst_count", count, 0);
    check("rst_enable", enable_out, 0);
    check("rst_busy", busy, 0);
    check("rst_pdone", period_done, 0);
    check("rst_cfgerr", config_error, 0);

    // Continuous run, period 10, ch0 threshold 3
    cfg_wr(4'd0, 32'd10);
    cfg_wr(4'd1, 32'd3);
    run = 1'b1;
    tick();
    check("arm_busy", busy, 1);
    check("arm_count", count, 0);
    for (int i = 0; i < 30; i++) begin
      tick();
      cnt = i % 10;
      check("t1_count", count, 64'(cnt));
      check("t1_enable", enable_out, (cnt == 3) ? 64'd1 : 64'd0);
      check("t1_pdone", period_done, (i >= 10 && cnt == 0) ? 64'd1 : 64'd0);
    end

    // Write ch1 threshold while count == 4: first fires in the following period
    for (int i = 0; i < 5; i++) tick();
    check("t2_count_at_write", count, 4);
    cfg_wr(4'd2, 32'd7);
    for (int j = 6; j <= 30; j++) begin
      tick();
      cnt = j % 10;
      exp_en = 4'd0;
      if (j < 30 && cnt == 3) exp_en[0] = 1'b1;
      if (j >= 10 && j < 30 && cnt == 7) exp_en[1] = 1'b1;
      check("t2_count", count, 64'(cnt));
      check("t2_enable", enable_out, exp_en);
      check("t2_busy", busy, (j < 30) ? 64'd1 : 64'd0);
      check("t2_pdone", period_done, (cnt == 0) ? 64'd1 : 64'd0);
      // Dropping run mid-period must let the period finish
      if (j == 25) run = 1'b0;
    end
    tick();
    check("t2_idle_pdone", period_done, 0);
    check("t2_idle_busy", busy, 0);

    // Single shot, period 8, ch0 threshold 2; a second pulse while busy is ignored
    cfg_wr(4'd0, 32'd8);
    cfg_wr(4'd1, 32'd2);
    cfg_wr(4'd2, 32'd0);
    single_shot = 1'b1;
    tick();
    single_shot = 1'b0;
    check("t3_arm_busy", busy, 1);
    busy_cycles = 1;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (busy) busy_cycles++;
      check("t3_busy", busy, (k < 8) ? 64'd1 : 64'd0);
      check("t3_count", count, (k < 8) ? 64'(k) : 64'd0);
      check("t3_enable", enable_out, (k == 2) ? 64'd1 : 64'd0);
      check("t3_pdone", period_done, (k == 8) ? 64'd1 : 64'd0);
      single_shot = (k == 4);
    end
    single_shot = 1'b0;
    // one ARM cycle plus eight RUN cycles
    check("t3_busy_cycles", 64'(busy_cycles), 9);

    // Period 1 is rejected
    cfg_wr(4'd0, 32'd1);
    run = 1'b1;
    tick();
    check("t4_arm_busy", busy, 1);
    check("t4_arm_cfgerr", config_error, 0);
    tick();
    check("t4_cfgerr", config_error, 1);
    check("t4_busy", busy, 0);
    check("t4_enable", enable_out, 0);
    run = 1'b0;
    tick();
    check("t4_cfgerr_clear", config_error, 0);
    check("t4_enable_after", enable_out, 0);

    // Reset mid-period at count == 5
    cfg_wr(4'd0, 32'd10);
    cfg_wr(4'd1, 32'd3);
    run = 1'b1;
    tick(); tick();
    for (int i = 0; i < 5; i++) tick();
    check("t5_count_before", count, 5);
    reset = 1'b0;
    run = 1'b0;
    tick();
    check("t5_count", count, 0);
    check("t5_enable", enable_out, 0);
    check("t5_busy", busy, 0);
    check("t5_pdone", period_done, 0);
    reset = 1'b1;
    run = 1'b1;
    tick();
    check("t5_rerun_arm", busy, 1);
    tick();
    check("t5_rerun_cfgerr", config_error, 1);
    check("t5_rerun_busy", busy, 0);
    run = 1'b0;
    tick();

    // Thresholds were cleared by reset: channels stay silent with a valid period
    cfg_wr(4'd0, 32'd10);
    run = 1'b1;
    tick();
    for (int i = 0; i < 13; i++) begin
      tick();
      check("t5_thr_cleared", enable_out, 0);
    end
    run = 1'b0;
    waited = 1'b0;
    for (int i = 0; i < 20 && !waited; i++) begin
      tick();
      if (!busy) waited = 1'b1;
    end
    check("t5_idle_reached", 64'(waited), 1);

    // Threshold 9 at period 10: pulse at count 9, or high 9..4 in clock mode
    cfg_wr(4'd1, 32'd9);
    run = 1'b1;
    tick();
    for (int j = 0; j < 20; j++) begin
      tick();
      cnt = j % 10;
`ifdef ENABLE_SEQUENCER_CLOCK_MODE_EN
      check("t6_enable", enable_out, ((cnt == 9) || (j >= 10 && cnt <= 4)) ? 64'd1 : 64'd0);
`else
      check("t6_enable", enable_out, (cnt == 9) ? 64'd1 : 64'd0);
`endif
      check("t6_count", count, 64'(cnt));
    end
    run = 1'b0;
    tick();
    check("t6_idle_enable", enable_out, 0);
    check("t6_idle_busy", busy, 0);
    check("t6_idle_pdone", period_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
